// File: rtl/updown_counter_param.sv
// Modulo-MODULUS up/down counter with parallel load, wrap/saturate/one-shot
// boundary modes, a combinational terminal-count flag and registered wrap/done flags.
module updown_counter_param #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             done
);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_RESERVED = 2'b11
  } mode_t;

  // Compared in WIDTH+1 bits so MODULUS == 2**WIDTH does not overflow.
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             done_nxt;
  logic [WIDTH:0]   load_ext;
  mode_t            mode_e;

  assign load_ext = {1'b0, load_val};
  assign mode_e   = mode_t'(mode);
  assign tc       = up_dn ? (q == MAX_Q) : (q == '0);

  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    done_nxt = done;
    if (load) begin
      q_nxt    = (load_ext > MAX_EXT) ? MAX_Q : load_val;
      done_nxt = 1'b0;
    end else if (en && !done) begin
      if (tc) begin
        case (mode_e)
          MODE_SAT:     q_nxt = q;
          MODE_ONESHOT: done_nxt = 1'b1;
          default: begin
            // MODE_WRAP and MODE_RESERVED both wrap around the range.
            q_nxt    = up_dn ? '0 : MAX_Q;
            wrap_nxt = 1'b1;
          end
        endcase
      end else begin
        q_nxt = up_dn ? (q + WIDTH'(1)) : (q - WIDTH'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q    <= '0;
      wrap <= 1'b0;
      done <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
      done <= done_nxt;
    end
  end

endmodule
